// File: rtl/pb_write_sched_if.sv
// rtl/pb_write_sched_if.sv - CPU, fill-engine and pixel-buffer write-port signals of pb_write_sched
interface pb_write_sched_if;
    logic [14:0] cpu_adr;
    logic [3:0]  cpu_data;
    logic        cpu_wren;
    logic [7:0]  fill_x0;
    logic [6:0]  fill_y0;
    logic [7:0]  fill_w;
    logic [6:0]  fill_h;
    logic [3:0]  fill_colour;
    logic        fill_start;
    logic        fill_abort;
    logic        fill_busy;
    logic        fill_done;
    logic [14:0] pb_wraddress;
    logic [3:0]  pb_data;
    logic        pb_wren;

    modport master (
        output cpu_adr, cpu_data, cpu_wren,
        output fill_x0, fill_y0, fill_w, fill_h, fill_colour, fill_start, fill_abort,
        input  fill_busy, fill_done, pb_wraddress, pb_data, pb_wren
    );

    modport slave (
        input  cpu_adr, cpu_data, cpu_wren,
        input  fill_x0, fill_y0, fill_w, fill_h, fill_colour, fill_start, fill_abort,
        output fill_busy, fill_done, pb_wraddress, pb_data, pb_wren
    );
endinterface

// File: rtl/pb_write_sched.sv
// rtl/pb_write_sched.sv - pixel-buffer write-port scheduler: CPU PIO writes over a rectangle-fill engine
module pb_write_sched #(
    parameter int H_RES = 160,
    parameter int V_RES = 120
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    pb_write_sched_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_LOAD, S_FILL, S_DONE} state_t;

    state_t      state;
    logic        cpu_wren_q;
    logic        fill_start_q;
    logic        pend_valid;
    logic [14:0] pend_adr;
    logic [3:0]  pend_data;
    logic [7:0]  x0_l;
    logic [6:0]  y0_l;
    logic [7:0]  w_l;
    logic [6:0]  h_l;
    logic [3:0]  colour_l;
    logic [14:0] row_base;
    logic [7:0]  ew;
    logic [6:0]  eh;
    logic        empty;
    logic [7:0]  col;
    logic [6:0]  row;

    logic        cpu_edge;
    logic        start_edge;
    logic [14:0] base_mul;
    logic [8:0]  x_room;
    logic [7:0]  y_room;
    logic [7:0]  ew_c;
    logic [6:0]  eh_c;
    logic        empty_c;
    logic        col_last;
    logic        row_last;

    assign cpu_edge   = bus.cpu_wren & ~cpu_wren_q;
    assign start_edge = bus.fill_start & ~fill_start_q;

    // Only the latched y0 feeds the multiplier; the product is registered in S_CALC.
    assign base_mul = 15'(y0_l) * 15'(H_RES);
    assign x_room   = 9'(H_RES) - {1'b0, x0_l};
    assign y_room   = 8'(V_RES) - {1'b0, y0_l};
    assign ew_c     = ({1'b0, w_l} < x_room) ? w_l : x_room[7:0];
    assign eh_c     = ({1'b0, h_l} < y_room) ? h_l : y_room[6:0];
    assign empty_c  = ({1'b0, x0_l} >= 9'(H_RES)) || ({1'b0, y0_l} >= 8'(V_RES)) ||
                      (w_l == 8'd0) || (h_l == 7'd0);
    assign col_last = (col == ew - 8'd1);
    assign row_last = (row == eh - 7'd1);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state            <= S_IDLE;
            cpu_wren_q       <= 1'b1;
            fill_start_q     <= 1'b1;
            pend_valid       <= 1'b0;
            pend_adr         <= '0;
            pend_data        <= '0;
            x0_l             <= '0;
            y0_l             <= '0;
            w_l              <= '0;
            h_l              <= '0;
            colour_l         <= '0;
            row_base         <= '0;
            ew               <= '0;
            eh               <= '0;
            empty            <= 1'b0;
            col              <= '0;
            row              <= '0;
            bus.fill_busy    <= 1'b0;
            bus.fill_done    <= 1'b0;
            bus.pb_wraddress <= '0;
            bus.pb_data      <= '0;
            bus.pb_wren      <= 1'b0;
        end else begin
            cpu_wren_q    <= bus.cpu_wren;
            fill_start_q  <= bus.fill_start;
            bus.pb_wren   <= 1'b0;
            bus.fill_done <= 1'b0;

            // A full pending slot owns the write port this cycle.
            if (pend_valid) begin
                bus.pb_wraddress <= pend_adr;
                bus.pb_data      <= pend_data;
                bus.pb_wren      <= 1'b1;
            end
            if (cpu_edge) begin
                pend_valid <= 1'b1;
                pend_adr   <= bus.cpu_adr;
                pend_data  <= bus.cpu_data;
            end else if (pend_valid) begin
                pend_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        x0_l     <= bus.fill_x0;
                        y0_l     <= bus.fill_y0;
                        w_l      <= bus.fill_w;
                        h_l      <= bus.fill_h;
                        colour_l <= bus.fill_colour;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    row_base <= base_mul + {7'd0, x0_l};
                    ew       <= ew_c;
                    eh       <= eh_c;
                    empty    <= empty_c;
                    state    <= S_LOAD;
                end
                S_LOAD: begin
                    col <= '0;
                    row <= '0;
                    if (empty) begin
                        bus.fill_done <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        bus.fill_busy <= 1'b1;
                        state         <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus.fill_abort) begin
                        bus.fill_busy <= 1'b0;
                        state         <= S_IDLE;
                    end else if (!pend_valid) begin
                        bus.pb_wraddress <= row_base + {7'd0, col};
                        bus.pb_data      <= colour_l;
                        bus.pb_wren      <= 1'b1;
                        if (col_last) begin
                            col      <= '0;
                            row      <= row + 7'd1;
                            row_base <= row_base + 15'(H_RES);
                            if (row_last) begin
                                state <= S_DONE;
                            end
                        end else begin
                            col <= col + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    bus.fill_done <= 1'b1;
                    bus.fill_busy <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pb_write_sched.sv
// tb/tb_pb_write_sched.sv - self-checking bench for pb_write_sched with a write-order scoreboard
module tb_pb_write_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pb_write_sched_if bus();

    pb_write_sched #(.H_RES(160), .V_RES(120)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    typedef struct {
        int x0, y0, w, h, col;
        int exp_cnt, exp_first, exp_last;
    } fill_vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [14:0] last_addr = '0;
    logic [18:0] mon_e;
    logic [18:0] exp_q[$];
    fill_vec_t   vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Scoreboard: every pb_wren cycle must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (bus.pb_wren === 1'b1) begin
            wr_cnt++;
            last_addr = bus.pb_wraddress;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: actual addr %0d data %0d required no write",
                         bus.pb_wraddress, bus.pb_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(bus.pb_wraddress), 32'(mon_e[18:4]));
                check("write_data", 32'(bus.pb_data), 32'(mon_e[3:0]));
            end
        end
        if (bus.fill_done === 1'b1) done_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic model_push(input int x0, input int y0, input int w, input int h, input int col);
        int ew, eh;
        if (x0 >= 160 || y0 >= 120 || w == 0 || h == 0) return;
        ew = (w < 160 - x0) ? w : 160 - x0;
        eh = (h < 120 - y0) ? h : 120 - y0;
        for (int r = 0; r < eh; r++)
            for (int c = 0; c < ew; c++)
                exp_q.push_back({15'((y0 + r) * 160 + x0 + c), 4'(col)});
    endtask

    task automatic set_fill(input int x0, input int y0, input int w, input int h, input int col);
        bus.fill_x0     = 8'(x0);
        bus.fill_y0     = 7'(y0);
        bus.fill_w      = 8'(w);
        bus.fill_h      = 7'(h);
        bus.fill_colour = 4'(col);
        bus.fill_start  = 1'b1;
    endtask

    task automatic run_vec(input fill_vec_t v);
        int   w0, d0, busy_wr, cyc;
        logic prev_wren;
        bit   seen;
        w0 = wr_cnt; d0 = done_cnt; busy_wr = 0; seen = 0; prev_wren = 1'b0;
        model_push(v.x0, v.y0, v.w, v.h, v.col);
        set_fill(v.x0, v.y0, v.w, v.h, v.col);
        step();
        bus.fill_start = 1'b0;
        check("busy_at_k", 32'(bus.fill_busy), 0);
        step();
        check("busy_at_k1", 32'(bus.fill_busy), 0);
        step();
        if (v.exp_cnt == 0) begin
            check("empty_done_k2", 32'(bus.fill_done), 1);
            check("empty_busy_k2", 32'(bus.fill_busy), 0);
            step();
            check("empty_done_pulse", 32'(bus.fill_done), 0);
            check("empty_writes", wr_cnt - w0, 0);
        end else begin
            check("busy_at_k2", 32'(bus.fill_busy), 1);
            check("wren_at_k2", 32'(bus.pb_wren), 0);
            step();
            check("first_pixel_wren", 32'(bus.pb_wren), 1);
            check("first_pixel_addr", 32'(bus.pb_wraddress), v.exp_first);
            for (cyc = 0; cyc < 25000 && !seen; cyc++) begin
                if (bus.pb_wren === 1'b1 && bus.fill_busy === 1'b1) busy_wr++;
                prev_wren = bus.pb_wren;
                step();
                if (bus.fill_done === 1'b1) seen = 1;
            end
            check("done_seen", 32'(seen), 1);
            check("done_after_last_pixel", 32'(prev_wren), 1);
            check("busy_drops_with_done", 32'(bus.fill_busy), 0);
            check("last_pixel_addr", 32'(last_addr), v.exp_last);
            check("write_count", wr_cnt - w0, v.exp_cnt);
            check("busy_during_writes", busy_wr, v.exp_cnt);
            step();
            check("done_pulse_width", 32'(bus.fill_done), 0);
        end
        check("done_count", done_cnt - d0, 1);
        check("queue_drained", exp_q.size(), 0);
        steps(3);
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (bus.fill_done !== 1'b1 && cyc < budget) begin
            step();
            cyc++;
        end
        check("fill_done_within_budget", 32'(bus.fill_done), 1);
    endtask

    initial begin
        int w0, d0, cyc;
        vecs[0] = '{x0: 0,   y0: 0,   w: 160, h: 120, col: 0,  exp_cnt: 19200, exp_first: 0,     exp_last: 19199};
        vecs[1] = '{x0: 158, y0: 118, w: 5,   h: 5,   col: 7,  exp_cnt: 4,     exp_first: 19038, exp_last: 19199};
        vecs[2] = '{x0: 10,  y0: 10,  w: 4,   h: 2,   col: 3,  exp_cnt: 8,     exp_first: 1610,  exp_last: 1773};
        vecs[3] = '{x0: 20,  y0: 20,  w: 0,   h: 5,   col: 1,  exp_cnt: 0,     exp_first: 0,     exp_last: 0};
        vecs[4] = '{x0: 200, y0: 5,   w: 10,  h: 5,   col: 2,  exp_cnt: 0,     exp_first: 0,     exp_last: 0};
        vecs[5] = '{x0: 0,   y0: 119, w: 3,   h: 10,  col: 12, exp_cnt: 3,     exp_first: 19040, exp_last: 19042};
        vecs[6] = '{x0: 5,   y0: 120, w: 3,   h: 3,   col: 9,  exp_cnt: 0,     exp_first: 0,     exp_last: 0};

        bus.cpu_adr = '0; bus.cpu_data = '0; bus.cpu_wren = 1'b0;
        bus.fill_x0 = '0; bus.fill_y0 = '0; bus.fill_w = '0; bus.fill_h = '0;
        bus.fill_colour = '0; bus.fill_start = 1'b0; bus.fill_abort = 1'b0;
        rst_n = 1'b0;
        steps(3);
        check("reset_wraddress", 32'(bus.pb_wraddress), 0);
        check("reset_data", 32'(bus.pb_data), 0);
        check("reset_wren", 32'(bus.pb_wren), 0);
        check("reset_busy", 32'(bus.fill_busy), 0);
        check("reset_done", 32'(bus.fill_done), 0);
        rst_n = 1'b1;
        step();

        // Strobes held high through reset must not fire.
        w0 = wr_cnt;
        rst_n = 1'b0; bus.fill_start = 1'b1; bus.cpu_wren = 1'b1;
        set_fill(0, 0, 4, 4, 1);
        steps(3);
        rst_n = 1'b1;
        steps(6);
        check("held_start_no_busy", 32'(bus.fill_busy), 0);
        check("held_high_no_writes", wr_cnt - w0, 0);
        bus.fill_start = 1'b0; bus.cpu_wren = 1'b0;
        steps(2);

        // CPU write: one pulse, two cycles after the strobe rises.
        w0 = wr_cnt;
        bus.cpu_adr = 15'h1234; bus.cpu_data = 4'hA;
        exp_q.push_back({15'h1234, 4'hA});
        bus.cpu_wren = 1'b1;
        step();
        check("cpu_wren_edge_k", 32'(bus.pb_wren), 0);
        step();
        check("cpu_wren_edge_k1", 32'(bus.pb_wren), 1);
        step();
        check("cpu_wren_edge_k2", 32'(bus.pb_wren), 0);
        steps(2);
        bus.cpu_wren = 1'b0;
        steps(3);
        check("cpu_single_pulse", wr_cnt - w0, 1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Contention: CPU write lands on the 2nd fill pixel slot, fill pixel slips.
        w0 = wr_cnt;
        bus.cpu_adr = 15'h0005; bus.cpu_data = 4'hF;
        exp_q.push_back({15'd1610, 4'd3});
        exp_q.push_back({15'd5, 4'hF});
        for (int a = 1611; a <= 1613; a++) exp_q.push_back({15'(a), 4'd3});
        for (int a = 1770; a <= 1773; a++) exp_q.push_back({15'(a), 4'd3});
        set_fill(10, 10, 4, 2, 3);
        step();
        bus.fill_start = 1'b0;
        steps(2);
        bus.cpu_wren = 1'b1;
        step();
        check("contention_first_pixel", 32'(bus.pb_wraddress), 1610);
        step();
        check("contention_cpu_addr", 32'(bus.pb_wraddress), 5);
        bus.cpu_wren = 1'b0;
        wait_done(50, cyc);
        check("contention_done_cycle", cyc, 8);
        check("contention_writes", wr_cnt - w0, 9);
        check("contention_queue", exp_q.size(), 0);
        steps(3);

        // A second start edge during FILL is ignored.
        w0 = wr_cnt; d0 = done_cnt;
        model_push(10, 10, 4, 2, 3);
        set_fill(10, 10, 4, 2, 3);
        step();
        bus.fill_start = 1'b0;
        steps(3);
        set_fill(0, 0, 160, 120, 5);
        step();
        bus.fill_start = 1'b0;
        wait_done(50, cyc);
        steps(6);
        check("restart_ignored_writes", wr_cnt - w0, 8);
        check("restart_ignored_done", done_cnt - d0, 1);
        check("restart_ignored_busy", 32'(bus.fill_busy), 0);
        check("restart_queue", exp_q.size(), 0);

        // Abort at the 100th pixel.
        w0 = wr_cnt; d0 = done_cnt;
        model_push(0, 0, 160, 120, 5);
        set_fill(0, 0, 160, 120, 5);
        step();
        bus.fill_start = 1'b0;
        for (int i = 0; i < 500 && (wr_cnt - w0) < 99; i++) step();
        check("abort_reached_99", wr_cnt - w0, 99);
        bus.fill_abort = 1'b1;
        step();
        check("abort_busy_low", 32'(bus.fill_busy), 0);
        check("abort_no_pixel", 32'(bus.pb_wren), 0);
        bus.fill_abort = 1'b0;
        steps(20);
        check("abort_writes", wr_cnt - w0, 99);
        check("abort_no_done", done_cnt - d0, 0);
        exp_q.delete();

        // Reset mid-fill.
        w0 = wr_cnt; d0 = done_cnt;
        model_push(0, 0, 160, 120, 6);
        set_fill(0, 0, 160, 120, 6);
        step();
        bus.fill_start = 1'b0;
        for (int i = 0; i < 500 && (wr_cnt - w0) < 50; i++) step();
        check("reset_reached_50", wr_cnt - w0, 50);
        rst_n = 1'b0;
        step();
        check("midreset_wraddress", 32'(bus.pb_wraddress), 0);
        check("midreset_data", 32'(bus.pb_data), 0);
        check("midreset_wren", 32'(bus.pb_wren), 0);
        check("midreset_busy", 32'(bus.fill_busy), 0);
        check("midreset_done", 32'(bus.fill_done), 0);
        rst_n = 1'b1;
        steps(20);
        check("midreset_writes", wr_cnt - w0, 50);
        check("midreset_no_done", done_cnt - d0, 0);
        exp_q.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
